// File: rtl/dsp_capture_pkg.sv
// dsp_capture_pkg
//   Shared types and helpers for the ADC capture buffer.
//   - state_e : capture/readout FSM state encoding (visible on o_state)
//   - mode_e  : capture mode selected at arm time
//   - W       : word width of the default geometry (16 ways x 6 bits)
//   - start_addr_calc : first record word address for pre-trigger capture
package dsp_capture_pkg;

  localparam int ADC_WIDTH_DEF = 6;
  localparam int WAY_WIDTH_DEF = 16;
  localparam int DEPTH_DEF     = 256;
  localparam int W             = WAY_WIDTH_DEF * ADC_WIDTH_DEF;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARMED   = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_DONE    = 3'd3,
    ST_READ    = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    MODE_IMM  = 2'd0,
    MODE_TRIG = 2'd1,
    MODE_PRE  = 2'd2,
    MODE_RSVD = 2'd3
  } mode_e;

  // Oldest pre-trigger word sits pretrig entries behind the write pointer
  // seen at the trigger; depth is a power of two so masking gives the wrap.
  function automatic logic [31:0] start_addr_calc(input logic [31:0] wr_ptr,
                                                  input logic [31:0] pretrig,
                                                  input int          depth);
    return (wr_ptr - pretrig) & 32'(depth - 1);
  endfunction

endpackage

// File: rtl/dsp_capture_ram.sv
// dsp_capture_ram
//   Simple dual-port record memory: one write port, one registered read port.
//   i_clk   : clock
//   i_we    : write enable, i_waddr / i_wdata : write address / data
//   i_re    : read enable,  i_raddr           : read address
//   o_rdata : read data, valid the cycle after i_re
//   Contents are not reset.
module dsp_capture_ram #(
  parameter  int DEPTH = 256,
  parameter  int W     = 96,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_we,
  input  logic [PTR_W-1:0] i_waddr,
  input  logic [W-1:0]     i_wdata,
  input  logic             i_re,
  input  logic [PTR_W-1:0] i_raddr,
  output logic [W-1:0]     o_rdata
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) mem[i_waddr] <= i_wdata;
    if (i_re) o_rdata <= mem[i_raddr];
  end

endmodule

// File: rtl/dsp_capture_buf.sv
// dsp_capture_buf
//   Captures parallel ADC words into a DEPTH-word RAM (immediate, trigger-start
//   or pre-trigger mode, with decimation) and streams the record out one bit
//   per read strobe, LSB first (way 0 bit 0 first).
//   i_clk, i_rstb         : clock, asynchronous active-low reset
//   i_dat, i_dat_vld      : input word and its valid
//   i_mode, i_pretrig, i_decim : capture setup, sampled on arm
//   i_arm, i_abort, i_trig: capture control
//   i_rd_req, i_rd_stb    : start readout / advance one bit
//   o_bit, o_bit_vld      : readout bit and its valid
//   o_done                : record complete and readable
//   o_state               : FSM state
//   o_start_addr          : RAM address of the first record word
module dsp_capture_buf
  import dsp_capture_pkg::*;
#(
  parameter  int ADC_WIDTH = ADC_WIDTH_DEF,
  parameter  int WAY_WIDTH = WAY_WIDTH_DEF,
  parameter  int DEPTH     = DEPTH_DEF,
  localparam int PTR_W     = $clog2(DEPTH)
) (
  input  logic                                i_clk,
  input  logic                                i_rstb,
  input  logic [WAY_WIDTH-1:0][ADC_WIDTH-1:0] i_dat,
  input  logic                                i_dat_vld,
  input  logic [1:0]                          i_mode,
  input  logic [PTR_W-1:0]                    i_pretrig,
  input  logic [3:0]                          i_decim,
  input  logic                                i_arm,
  input  logic                                i_abort,
  input  logic                                i_trig,
  input  logic                                i_rd_req,
  input  logic                                i_rd_stb,
  output logic                                o_bit,
  output logic                                o_bit_vld,
  output logic                                o_done,
  output logic [2:0]                          o_state,
  output logic [PTR_W-1:0]                    o_start_addr
);

  localparam int DW    = WAY_WIDTH * ADC_WIDTH;
  localparam int CNT_W = PTR_W + 1;
  localparam int BIT_W = $clog2(DW);
  localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(DEPTH);
  localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(DW - 1);
  localparam logic [PTR_W-1:0] LAST_WORD = PTR_W'(DEPTH - 1);

  state_e           state_q, state_d;
  mode_e            mode_q, mode_d;
  logic [PTR_W-1:0] pretrig_q, pretrig_d;
  logic [3:0]       decim_q, decim_d;
  logic [3:0]       dec_cnt_q, dec_cnt_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] fill_q, fill_d;
  logic [CNT_W-1:0] post_q, post_d;
  logic             done_q, done_d;
  logic [PTR_W-1:0] start_addr_q, start_addr_d;
  logic [PTR_W-1:0] rd_addr_q, rd_addr_d;
  logic [PTR_W-1:0] rd_cnt_q, rd_cnt_d;
  logic [DW-1:0]    shift_q, shift_d;
  logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic             bit_vld_q, bit_vld_d;
  logic             ld_q, ld_d;

  logic             arm_acc, rd_acc;
  logic             trig_accept, capt_phase, store_en, store, capt_store;
  logic [CNT_W-1:0] post_target;
  logic             record_full;
  logic             strobe_ok, word_end, last_consumed, ram_re;
  logic [DW-1:0]    dat_flat, ram_rdata;

  assign dat_flat = i_dat;

  // ---------------------------------------------------------------------------
  // Qualifiers shared by the FSM and the datapath
  // ---------------------------------------------------------------------------
  always_comb begin
    arm_acc = (state_q == ST_IDLE || state_q == ST_DONE) && i_arm && !i_abort;
    rd_acc  = (state_q == ST_DONE) && i_rd_req && !i_arm && !i_abort;

    // Pre-trigger mode only honours a trigger once enough history is held.
    trig_accept = (state_q == ST_ARMED) && i_trig &&
                  ((mode_q == MODE_TRIG) ||
                   (mode_q == MODE_PRE && fill_q >= {1'b0, pretrig_q}));

    // capt_phase: cycles whose stores count towards the post-trigger record.
    capt_phase = (state_q == ST_CAPTURE) || trig_accept;
    store_en   = capt_phase || (state_q == ST_ARMED && mode_q == MODE_PRE);
    store      = store_en && i_dat_vld && (dec_cnt_q == 4'd0);
    capt_store = capt_phase && store;

    post_target = (mode_q == MODE_PRE) ? (DEPTH_C - {1'b0, pretrig_q}) : DEPTH_C;
    record_full = capt_store && ((post_q + CNT_W'(1)) == post_target);

    strobe_ok     = (state_q == ST_READ) && bit_vld_q && i_rd_stb;
    word_end      = strobe_ok && (bit_cnt_q == LAST_BIT);
    last_consumed = word_end && (rd_cnt_q == LAST_WORD);
    // Fetch the next word whenever the shifter is empty and no load is pending.
    ram_re        = (state_q == ST_READ) && !bit_vld_q && !ld_q;
  end

  // ---------------------------------------------------------------------------
  // State register and datapath flops
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rstb) begin
    if (!i_rstb) begin
      state_q      <= ST_IDLE;
      mode_q       <= MODE_IMM;
      pretrig_q    <= '0;
      decim_q      <= '0;
      dec_cnt_q    <= '0;
      wr_ptr_q     <= '0;
      fill_q       <= '0;
      post_q       <= '0;
      done_q       <= 1'b0;
      start_addr_q <= '0;
      rd_addr_q    <= '0;
      rd_cnt_q     <= '0;
      shift_q      <= '0;
      bit_cnt_q    <= '0;
      bit_vld_q    <= 1'b0;
      ld_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      pretrig_q    <= pretrig_d;
      decim_q      <= decim_d;
      dec_cnt_q    <= dec_cnt_d;
      wr_ptr_q     <= wr_ptr_d;
      fill_q       <= fill_d;
      post_q       <= post_d;
      done_q       <= done_d;
      start_addr_q <= start_addr_d;
      rd_addr_q    <= rd_addr_d;
      rd_cnt_q     <= rd_cnt_d;
      shift_q      <= shift_d;
      bit_cnt_q    <= bit_cnt_d;
      bit_vld_q    <= bit_vld_d;
      ld_q         <= ld_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    if (i_abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:    if (i_arm) state_d = ST_ARMED;
        ST_ARMED: begin
          if (record_full)
            state_d = ST_DONE;
          else if (mode_q == MODE_IMM || trig_accept)
            state_d = ST_CAPTURE;
        end
        ST_CAPTURE: if (record_full) state_d = ST_DONE;
        ST_DONE: begin
          if (i_arm)         state_d = ST_ARMED;
          else if (i_rd_req) state_d = ST_READ;
        end
        ST_READ:    if (last_consumed) state_d = ST_DONE;
        default:    state_d = ST_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath / registered-output next values
  // ---------------------------------------------------------------------------
  always_comb begin
    mode_d       = mode_q;
    pretrig_d    = pretrig_q;
    decim_d      = decim_q;
    dec_cnt_d    = dec_cnt_q;
    wr_ptr_d     = wr_ptr_q;
    fill_d       = fill_q;
    post_d       = post_q;
    done_d       = done_q;
    start_addr_d = start_addr_q;
    rd_addr_d    = rd_addr_q;
    rd_cnt_d     = rd_cnt_q;
    shift_d      = shift_q;
    bit_cnt_d    = bit_cnt_q;
    bit_vld_d    = bit_vld_q;
    ld_d         = ram_re && !i_abort;

    if (arm_acc) begin
      // Reserved mode behaves as immediate. i_pretrig is PTR_W bits wide, so
      // it can never exceed DEPTH-1 and needs no further clamping.
      mode_d       = (i_mode == 2'd3) ? MODE_IMM : mode_e'(i_mode);
      pretrig_d    = i_pretrig;
      decim_d      = i_decim;
      dec_cnt_d    = '0;
      wr_ptr_d     = '0;
      fill_d       = '0;
      post_d       = '0;
      done_d       = 1'b0;
      start_addr_d = '0;
    end

    // Decimation counts every valid word seen while storing is enabled.
    if (store_en && i_dat_vld)
      dec_cnt_d = (dec_cnt_q == decim_q) ? 4'd0 : dec_cnt_q + 4'd1;

    if (store) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (fill_q != DEPTH_C) fill_d = fill_q + CNT_W'(1);
    end

    if (capt_store) post_d = post_q + CNT_W'(1);

    if (trig_accept && mode_q == MODE_PRE)
      start_addr_d = PTR_W'(start_addr_calc(32'(wr_ptr_q), 32'(pretrig_q), DEPTH));

    if (record_full) done_d = 1'b1;

    if (rd_acc) begin
      rd_addr_d = start_addr_q;
      rd_cnt_d  = '0;
      bit_vld_d = 1'b0;
    end

    if (ld_q) begin
      shift_d   = ram_rdata;
      bit_cnt_d = '0;
      bit_vld_d = 1'b1;
    end

    if (strobe_ok) begin
      shift_d   = shift_q >> 1;
      bit_cnt_d = bit_cnt_q + BIT_W'(1);
      if (word_end) begin
        bit_vld_d = 1'b0;
        rd_cnt_d  = rd_cnt_q + PTR_W'(1);
        rd_addr_d = rd_addr_q + PTR_W'(1);
      end
    end

    if (i_abort) begin
      done_d    = 1'b0;
      bit_vld_d = 1'b0;
    end
  end

  dsp_capture_ram #(
    .DEPTH (DEPTH),
    .W     (DW)
  ) u_ram (
    .i_clk   (i_clk),
    .i_we    (store),
    .i_waddr (wr_ptr_q),
    .i_wdata (dat_flat),
    .i_re    (ram_re),
    .i_raddr (rd_addr_q),
    .o_rdata (ram_rdata)
  );

  assign o_bit        = shift_q[0];
  assign o_bit_vld    = bit_vld_q;
  assign o_done       = done_q;
  assign o_state      = state_q;
  assign o_start_addr = start_addr_q;

endmodule

// File: tb/tb_dsp_capture_buf.sv
module tb_dsp_capture_buf;

  localparam int ADC   = 4;
  localparam int WAYS  = 2;
  localparam int DEPTH = 16;
  localparam int DW    = ADC * WAYS;
  localparam int NBITS = DEPTH * DW;

  logic                     clk = 1'b0;
  logic                     rstb;
  logic [WAYS-1:0][ADC-1:0] dat;
  logic                     dat_vld, arm, abort, trig, rd_req, rd_stb;
  logic [1:0]               mode;
  logic [3:0]               pretrig;
  logic [3:0]               decim;
  logic                     o_bit, o_bit_vld, o_done;
  logic [2:0]               o_state;
  logic [3:0]               o_start_addr;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] got_words [DEPTH];

  dsp_capture_buf #(
    .ADC_WIDTH (ADC),
    .WAY_WIDTH (WAYS),
    .DEPTH     (DEPTH)
  ) dut (
    .i_clk        (clk),
    .i_rstb       (rstb),
    .i_dat        (dat),
    .i_dat_vld    (dat_vld),
    .i_mode       (mode),
    .i_pretrig    (pretrig),
    .i_decim      (decim),
    .i_arm        (arm),
    .i_abort      (abort),
    .i_trig       (trig),
    .i_rd_req     (rd_req),
    .i_rd_stb     (rd_stb),
    .o_bit        (o_bit),
    .o_bit_vld    (o_bit_vld),
    .o_done       (o_done),
    .o_state      (o_state),
    .o_start_addr (o_start_addr)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_arm(input logic [1:0] m, input logic [3:0] p, input logic [3:0] d);
    mode = m; pretrig = p; decim = d; arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  // Drive a ramp start, start+1, ... every cycle until o_done or budget.
  task automatic feed(input int start, input int trig_a, input int trig_b, output int fed);
    fed = 0;
    while (!o_done && fed < 300) begin
      dat     = 8'(start + fed);
      dat_vld = 1'b1;
      trig    = ((start + fed) == trig_a) || ((start + fed) == trig_b);
      tick();
      fed++;
    end
    dat_vld = 1'b0;
    trig    = 1'b0;
  endtask

  // Request readout and strobe continuously; collect bits while o_bit_vld.
  task automatic read_record(output int nbits, output int first_lat, output int max_gap,
                             output logic [2:0] st_read, output logic done_all,
                             output logic [2:0] st_end, output logic vld_end);
    int  edges;
    int  gap;
    bit  seen;
    nbits = 0; first_lat = -1; max_gap = 0; gap = 0; seen = 0; done_all = 1'b1;
    rd_req = 1'b1;
    tick();
    rd_req  = 1'b0;
    st_read = o_state;
    rd_stb  = 1'b1;
    edges   = 0;
    while (nbits < NBITS && edges < 3000) begin
      done_all = done_all & o_done;
      if (o_bit_vld) begin
        if (!seen) begin first_lat = edges; seen = 1; end
        if (gap > max_gap) max_gap = gap;
        gap = 0;
        got_words[nbits / DW][nbits % DW] = o_bit;
        nbits++;
      end else if (seen) begin
        gap++;
      end
      tick();
      edges++;
    end
    rd_stb  = 1'b0;
    st_end  = o_state;
    vld_end = o_bit_vld;
  endtask

  task automatic test_reset();
    rstb = 1'b0;
    repeat (2) tick();
    total++; if (o_state !== 3'd0) begin bad++; $display("FAIL reset_state got=%0d exp=0", o_state); end
    total++; if (o_bit !== 1'b0) begin bad++; $display("FAIL reset_bit got=%b exp=0", o_bit); end
    total++; if (o_bit_vld !== 1'b0) begin bad++; $display("FAIL reset_bit_vld got=%b exp=0", o_bit_vld); end
    total++; if (o_done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", o_done); end
    total++; if (o_start_addr !== 4'd0) begin bad++; $display("FAIL reset_start got=%0d exp=0", o_start_addr); end
    rstb = 1'b1;
    tick();
    total++; if (o_state !== 3'd0) begin bad++; $display("FAIL idle_after_reset got=%0d exp=0", o_state); end
    $display("reset: state=%0d done=%b", o_state, o_done);
  endtask

  task automatic test_mode0_immediate();
    int fed, nb, lat, gap;
    logic [2:0] sr, se; logic da, ve;
    do_arm(2'd0, 4'd0, 4'd0);
    total++; if (o_state !== 3'd1) begin bad++; $display("FAIL m0_armed got=%0d exp=1", o_state); end
    tick();
    total++; if (o_state !== 3'd2) begin bad++; $display("FAIL m0_capture got=%0d exp=2", o_state); end
    feed(0, -1, -1, fed);
    total++; if (fed !== 16) begin bad++; $display("FAIL m0_fed got=%0d exp=16", fed); end
    total++; if (o_state !== 3'd3 || o_done !== 1'b1) begin bad++; $display("FAIL m0_done state=%0d done=%b exp 3/1", o_state, o_done); end
    total++; if (o_start_addr !== 4'd0) begin bad++; $display("FAIL m0_start got=%0d exp=0", o_start_addr); end
    read_record(nb, lat, gap, sr, da, se, ve);
    total++; if (sr !== 3'd4) begin bad++; $display("FAIL m0_read_state got=%0d exp=4", sr); end
    total++; if (da !== 1'b1) begin bad++; $display("FAIL m0_done_in_read got=%b exp=1", da); end
    total++; if (nb !== NBITS) begin bad++; $display("FAIL m0_nbits got=%0d exp=%0d", nb, NBITS); end
    total++; if (lat !== 2) begin bad++; $display("FAIL m0_first_latency got=%0d exp=2", lat); end
    total++; if (gap !== 2) begin bad++; $display("FAIL m0_word_gap got=%0d exp=2", gap); end
    total++; if (se !== 3'd3 || ve !== 1'b0) begin bad++; $display("FAIL m0_read_end state=%0d vld=%b exp 3/0", se, ve); end
    for (int k = 0; k < DEPTH; k++) begin
      total++;
      if (got_words[k] !== 8'(k)) begin bad++; $display("FAIL m0_word[%0d] got=%0d exp=%0d", k, got_words[k], k); end
    end
    $display("mode0: fed=%0d bits=%0d latency=%0d gap=%0d", fed, nb, lat, gap);
    // The record stays readable from DONE.
    read_record(nb, lat, gap, sr, da, se, ve);
    total++; if (nb !== NBITS) begin bad++; $display("FAIL reread_nbits got=%0d exp=%0d", nb, NBITS); end
    for (int k = 0; k < DEPTH; k++) begin
      total++;
      if (got_words[k] !== 8'(k)) begin bad++; $display("FAIL reread_word[%0d] got=%0d exp=%0d", k, got_words[k], k); end
    end
    $display("reread: bits=%0d end_state=%0d", nb, se);
  endtask

  task automatic test_mode1_trigger();
    int fed, nb, lat, gap;
    logic [2:0] sr, se; logic da, ve;
    do_arm(2'd1, 4'd0, 4'd0);
    total++; if (o_done !== 1'b0) begin bad++; $display("FAIL m1_done_cleared got=%b exp=0", o_done); end
    feed(0, 40, -1, fed);
    total++; if (fed !== 56) begin bad++; $display("FAIL m1_fed got=%0d exp=56", fed); end
    total++; if (o_start_addr !== 4'd0) begin bad++; $display("FAIL m1_start got=%0d exp=0", o_start_addr); end
    read_record(nb, lat, gap, sr, da, se, ve);
    total++; if (nb !== NBITS) begin bad++; $display("FAIL m1_nbits got=%0d exp=%0d", nb, NBITS); end
    for (int k = 0; k < DEPTH; k++) begin
      total++;
      if (got_words[k] !== 8'(40 + k)) begin bad++; $display("FAIL m1_word[%0d] got=%0d exp=%0d", k, got_words[k], 40 + k); end
    end
    $display("mode1: fed=%0d start=%0d first=%0d last=%0d", fed, o_start_addr, got_words[0], got_words[DEPTH-1]);
  endtask

  task automatic test_mode2_pretrig();
    int fed, nb, lat, gap;
    logic [2:0] sr, se; logic da, ve;
    do_arm(2'd2, 4'd4, 4'd0);
    feed(0, 20, -1, fed);
    total++; if (fed !== 32) begin bad++; $display("FAIL m2_fed got=%0d exp=32", fed); end
    total++; if (o_start_addr !== 4'd0) begin bad++; $display("FAIL m2_start got=%0d exp=0", o_start_addr); end
    read_record(nb, lat, gap, sr, da, se, ve);
    for (int k = 0; k < DEPTH; k++) begin
      total++;
      if (got_words[k] !== 8'(16 + k)) begin bad++; $display("FAIL m2_word[%0d] got=%0d exp=%0d", k, got_words[k], 16 + k); end
    end
    $display("mode2: fed=%0d start=%0d first=%0d", fed, o_start_addr, got_words[0]);
  endtask

  task automatic test_mode2_early_trigger();
    int fed, nb, lat, gap;
    logic [2:0] sr, se; logic da, ve;
    do_arm(2'd2, 4'd4, 4'd0);
    // Trigger on word 1 comes too early; trigger on word 9 (wr_ptr 9) counts.
    feed(0, 1, 9, fed);
    total++; if (fed !== 21) begin bad++; $display("FAIL m2e_fed got=%0d exp=21", fed); end
    total++; if (o_start_addr !== 4'd5) begin bad++; $display("FAIL m2e_start got=%0d exp=5", o_start_addr); end
    read_record(nb, lat, gap, sr, da, se, ve);
    for (int k = 0; k < DEPTH; k++) begin
      total++;
      if (got_words[k] !== 8'(5 + k)) begin bad++; $display("FAIL m2e_word[%0d] got=%0d exp=%0d", k, got_words[k], 5 + k); end
    end
    $display("mode2_early: fed=%0d start=%0d first=%0d", fed, o_start_addr, got_words[0]);
  endtask

  task automatic test_decimation();
    int fed, nb, lat, gap;
    logic [2:0] sr, se; logic da, ve;
    do_arm(2'd0, 4'd0, 4'd2);
    tick();
    feed(0, -1, -1, fed);
    total++; if (fed !== 46) begin bad++; $display("FAIL decim_fed got=%0d exp=46", fed); end
    read_record(nb, lat, gap, sr, da, se, ve);
    for (int k = 0; k < DEPTH; k++) begin
      total++;
      if (got_words[k] !== 8'(3 * k)) begin bad++; $display("FAIL decim_word[%0d] got=%0d exp=%0d", k, got_words[k], 3 * k); end
    end
    $display("decim: fed=%0d last=%0d", fed, got_words[DEPTH-1]);
  endtask

  task automatic test_abort();
    // From DONE, abort together with arm: abort wins.
    abort = 1'b1; arm = 1'b1;
    tick();
    abort = 1'b0; arm = 1'b0;
    total++; if (o_state !== 3'd0) begin bad++; $display("FAIL abort_beats_arm state=%0d exp=0", o_state); end
    total++; if (o_done !== 1'b0) begin bad++; $display("FAIL abort_done got=%b exp=0", o_done); end
    do_arm(2'd0, 4'd0, 4'd0);
    tick();
    for (int k = 0; k < 5; k++) begin
      dat = 8'(k); dat_vld = 1'b1;
      tick();
    end
    dat_vld = 1'b0;
    total++; if (o_state !== 3'd2) begin bad++; $display("FAIL abort_pre_capture state=%0d exp=2", o_state); end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    total++; if (o_state !== 3'd0 || o_done !== 1'b0) begin bad++; $display("FAIL abort_capture state=%0d done=%b exp 0/0", o_state, o_done); end
    $display("abort: state=%0d done=%b", o_state, o_done);
  endtask

  task automatic test_async_reset_rearm();
    int fed, nb, lat, gap;
    logic [2:0] sr, se; logic da, ve;
    do_arm(2'd0, 4'd0, 4'd0);
    tick();
    feed(200, -1, -1, fed);
    rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
    rd_stb = 1'b1;
    repeat (20) tick();
    rd_stb = 1'b0;
    total++; if (o_state !== 3'd4) begin bad++; $display("FAIL rst_pre_state got=%0d exp=4", o_state); end
    #3;
    rstb = 1'b0;
    #1;
    total++; if (o_state !== 3'd0) begin bad++; $display("FAIL arst_state got=%0d exp=0", o_state); end
    total++; if (o_bit !== 1'b0 || o_bit_vld !== 1'b0) begin bad++; $display("FAIL arst_bit bit=%b vld=%b exp 0/0", o_bit, o_bit_vld); end
    total++; if (o_done !== 1'b0 || o_start_addr !== 4'd0) begin bad++; $display("FAIL arst_done done=%b start=%0d exp 0/0", o_done, o_start_addr); end
    tick();
    #3;
    rstb = 1'b1;
    tick();
    do_arm(2'd0, 4'd0, 4'd0);
    tick();
    feed(100, -1, -1, fed);
    total++; if (fed !== 16) begin bad++; $display("FAIL rearm_fed got=%0d exp=16", fed); end
    read_record(nb, lat, gap, sr, da, se, ve);
    for (int k = 0; k < DEPTH; k++) begin
      total++;
      if (got_words[k] !== 8'(100 + k)) begin bad++; $display("FAIL rearm_word[%0d] got=%0d exp=%0d", k, got_words[k], 100 + k); end
    end
    $display("async_reset_rearm: fed=%0d first=%0d", fed, got_words[0]);
  endtask

  initial begin
    rstb = 1'b0; dat = '0; dat_vld = 1'b0; mode = 2'd0; pretrig = 4'd0; decim = 4'd0;
    arm = 1'b0; abort = 1'b0; trig = 1'b0; rd_req = 1'b0; rd_stb = 1'b0;
    test_reset();
    test_mode0_immediate();
    test_mode1_trigger();
    test_mode2_pretrig();
    test_mode2_early_trigger();
    test_decimation();
    test_abort();
    test_async_reset_rearm();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
